// File: rtl/fpdlink_rx_decode.sv
// fpdlink_rx_decode
//   FPD-Link I receive decoder. Unpacks aligned 7-bit lane words from the
//   LVDS deserialiser into RGB888 pixels plus sync. It measures the active
//   width/height of every frame and forwards vsync only once the timing has
//   been stable for STABLE_FRAMES consecutive frames.
//
// Ports
//   clk         pixel clock; everything runs on its rising edge
//   rst         synchronous active-high reset
//   din_valid   deserialiser aligned; din is garbage while low
//   din         CHANNELS*LANES*7 lane words, channel 0 / lane 0 in the MSBs
//   v_vsync     vsync, passed only while locked
//   v_hsync     hsync (channel 0)
//   v_de        data enable (channel 0)
//   v_pixel     CHANNELS x RGB888, channel 0 in the MSBs, R is the top byte
//   v_active_w  latched active width in pixels (line width * CHANNELS)
//   v_active_h  latched active height in lines
//   v_locked    timing locked
//   v_err       one-cycle pulse when lock is lost
module fpdlink_rx_decode #(
  parameter int    CHANNELS      = 2,
  parameter int    LANES         = 3,
  parameter string MAPPING       = "VESA",
  parameter int    SKIP_FRAMES   = 5,
  parameter int    STABLE_FRAMES = 2,
  parameter int    CNT_W         = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic [CHANNELS*LANES*7-1:0] din,
  output logic                       v_vsync,
  output logic                       v_hsync,
  output logic                       v_de,
  output logic [CHANNELS*24-1:0]     v_pixel,
  output logic [CNT_W:0]             v_active_w,
  output logic [CNT_W-1:0]           v_active_h,
  output logic                       v_locked,
  output logic                       v_err
);

  localparam int WORD_W = LANES * 7;
  localparam int DIN_W  = CHANNELS * WORD_W;
  // LSB offsets of lanes 0..2 inside one channel word
  localparam int L0 = (LANES - 1) * 7;
  localparam int L1 = (LANES - 2) * 7;
  localparam int L2 = (LANES - 3) * 7;
  localparam bit USE_JEIDA = (MAPPING == "JEIDA");
  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  // One spare count so stable_cnt+1 never wraps, also when STABLE_FRAMES=1
  localparam int STB_W  = $clog2(STABLE_FRAMES + 2);

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Unpack one channel word into {R,G,B}. Lanes 0-2 carry a 6-bit payload
  // per colour; lane 3 (24-bit mode) carries the remaining two bits, which
  // go on top (VESA) or underneath (JEIDA).
  function automatic logic [23:0] decode_ch(input logic [WORD_W-1:0] w);
    logic [5:0] pr, pg, pb;
    logic [7:0] r, g, b;
    pr = w[L0+5 -: 6];
    pg = {w[L1+4 -: 5], w[L0+6]};
    pb = {w[L2+3 -: 4], w[L1+6 -: 2]};
    if (LANES == 3) begin
      r = {pr, 2'b00};
      g = {pg, 2'b00};
      b = {pb, 2'b00};
    end else if (USE_JEIDA) begin
      r = {pr, w[1:0]};
      g = {pg, w[3:2]};
      b = {pb, w[5:4]};
    end else begin
      r = {w[1:0], pr};
      g = {w[3:2], pg};
      b = {w[5:4], pb};
    end
    return {r, g, b};
  endfunction

  // ---- stage 1: register lane words ----
  logic [DIN_W-1:0] din_p1;
  logic             vld_p1;

  always_ff @(posedge clk) begin
    din_p1 <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= din_valid;
  end

  // ---- stage 1 -> 2: decode, measure, lock FSM ----
  logic [WORD_W-1:0]     ch0_p1;
  logic                  de_p1, vs_p1, hs_p1;
  logic [DIN_W/WORD_W*24-1:0] pix_p1;

  assign ch0_p1 = din_p1[DIN_W-1 -: WORD_W];
  assign de_p1  = vld_p1 & ch0_p1[L2+6];
  assign vs_p1  = vld_p1 & ch0_p1[L2+5];
  assign hs_p1  = vld_p1 & ch0_p1[L2+4];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign pix_p1[(CHANNELS-c)*24-1 -: 24] =
      decode_ch(din_p1[(CHANNELS-c)*WORD_W-1 -: WORD_W]);
  end

  logic             de_d, vs_d;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] frm_w, frm_h;
  logic             frm_bad;
  logic             vs_rise, de_fall;

  assign vs_rise = vs_p1 & ~vs_d;
  assign de_fall = de_d & ~de_p1;

  // Frame statistics as they stand including a line ending on this cycle,
  // so a frame is judged complete even if its last DE fall is coincident.
  logic [CNT_W-1:0] fw_c, fh_c;
  logic             bad_c;

  always_comb begin
    fw_c  = frm_w;
    fh_c  = frm_h;
    bad_c = frm_bad;
    if (de_fall) begin
      if (frm_h == '0)           fw_c  = line_cnt;
      else if (line_cnt != frm_w) bad_c = 1'b1;
      fh_c = sat_inc(frm_h);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !vld_p1) begin
      de_d     <= 1'b0;
      vs_d     <= 1'b0;
      line_cnt <= '0;
      frm_w    <= '0;
      frm_h    <= '0;
      frm_bad  <= 1'b0;
    end else begin
      de_d <= de_p1;
      vs_d <= vs_p1;
      if (de_p1) line_cnt <= de_d ? sat_inc(line_cnt) : CNT_W'(1);
      if (vs_rise) begin
        frm_w   <= '0;
        frm_h   <= '0;
        frm_bad <= 1'b0;
      end else begin
        frm_w   <= fw_c;
        frm_h   <= fh_c;
        frm_bad <= bad_c;
      end
    end
  end

  logic consistent, same_prev;
  state_t            state, state_n;
  logic [SKIP_W-1:0] skip_cnt, skip_n;
  logic [STB_W-1:0]  stable_cnt, stable_n;
  logic [CNT_W-1:0]  prev_w, prev_h, prev_w_n, prev_h_n;
  logic              latch_n, err_n;

  assign consistent = ~bad_c & (fw_c != '0) & (fh_c != '0);
  // While locked, prev_w/prev_h are exactly the latched timing.
  assign same_prev  = (fw_c == prev_w) & (fh_c == prev_h);

  always_comb begin
    state_n  = state;
    skip_n   = skip_cnt;
    stable_n = stable_cnt;
    prev_w_n = prev_w;
    prev_h_n = prev_h;
    latch_n  = 1'b0;
    err_n    = 1'b0;
    if (!vld_p1) begin
      state_n  = ST_SKIP;
      skip_n   = '0;
      stable_n = '0;
      err_n    = (state == ST_LOCKED);
    end else if (vs_rise) begin
      case (state)
        ST_SKIP: begin
          if (skip_cnt == SKIP_W'(SKIP_FRAMES - 1)) begin
            state_n  = ST_TRAIN;
            skip_n   = '0;
            stable_n = '0;
            prev_w_n = '0;
            prev_h_n = '0;
          end else begin
            skip_n = skip_cnt + 1'b1;
          end
        end
        ST_TRAIN: begin
          if (!consistent) begin
            stable_n = '0;
          end else begin
            stable_n = same_prev ? stable_cnt + 1'b1 : STB_W'(1);
            prev_w_n = fw_c;
            prev_h_n = fh_c;
          end
          if (stable_n >= STB_W'(STABLE_FRAMES)) begin
            state_n = ST_LOCKED;
            latch_n = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!consistent || !same_prev) begin
            state_n  = ST_TRAIN;
            err_n    = 1'b1;
            stable_n = consistent ? STB_W'(1) : '0;
            if (consistent) begin
              prev_w_n = fw_c;
              prev_h_n = fh_c;
            end
          end
        end
        default: state_n = ST_SKIP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SKIP;
      skip_cnt   <= '0;
      stable_cnt <= '0;
      prev_w     <= '0;
      prev_h     <= '0;
      v_active_w <= '0;
      v_active_h <= '0;
      v_locked   <= 1'b0;
      v_err      <= 1'b0;
    end else begin
      state      <= state_n;
      skip_cnt   <= skip_n;
      stable_cnt <= stable_n;
      prev_w     <= prev_w_n;
      prev_h     <= prev_h_n;
      if (latch_n) begin
        v_active_w <= (CNT_W+1)'(fw_c) * (CNT_W+1)'(CHANNELS);
        v_active_h <= fh_c;
      end
      v_locked <= (state_n == ST_LOCKED);
      v_err    <= err_n;
    end
  end

  // ---- stage 2: registered outputs ----
  // Gating with state_n makes the locking vsync pulse pass whole and the
  // lock-breaking pulse disappear whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_vsync <= 1'b0;
      v_hsync <= 1'b0;
      v_de    <= 1'b0;
      v_pixel <= '0;
    end else begin
      v_vsync <= vs_p1 & (state_n == ST_LOCKED);
      v_hsync <= hs_p1;
      v_de    <= de_p1;
      v_pixel <= vld_p1 ? pix_p1 : '0;
    end
  end

endmodule

// File: tb/tb_fpdlink_rx_decode.sv
module tb_fpdlink_rx_decode;

  localparam int CH  = 2;
  localparam int CW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, din_valid;
  logic [55:0] din_v, din_j;
  logic [41:0] din_3;

  logic        vs_v, hs_v, de_v, lk_v, er_v;
  logic [47:0] px_v;
  logic [CW:0] aw_v;
  logic [CW-1:0] ah_v;
  logic        vs_j, hs_j, de_j, lk_j, er_j;
  logic [47:0] px_j;
  logic [CW:0] aw_j;
  logic [CW-1:0] ah_j;
  logic        vs_3, hs_3, de_3, lk_3, er_3;
  logic [47:0] px_3;
  logic [CW:0] aw_3;
  logic [CW-1:0] ah_3;

  fpdlink_rx_decode #(.CHANNELS(CH), .LANES(4), .MAPPING("VESA"),
    .SKIP_FRAMES(2), .STABLE_FRAMES(2), .CNT_W(CW)) u_vesa (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din_v),
    .v_vsync(vs_v), .v_hsync(hs_v), .v_de(de_v), .v_pixel(px_v),
    .v_active_w(aw_v), .v_active_h(ah_v), .v_locked(lk_v), .v_err(er_v));

  fpdlink_rx_decode #(.CHANNELS(CH), .LANES(4), .MAPPING("JEIDA"),
    .SKIP_FRAMES(2), .STABLE_FRAMES(2), .CNT_W(CW)) u_jeida (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din_j),
    .v_vsync(vs_j), .v_hsync(hs_j), .v_de(de_j), .v_pixel(px_j),
    .v_active_w(aw_j), .v_active_h(ah_j), .v_locked(lk_j), .v_err(er_j));

  fpdlink_rx_decode #(.CHANNELS(CH), .LANES(3), .MAPPING("VESA"),
    .SKIP_FRAMES(2), .STABLE_FRAMES(2), .CNT_W(CW)) u_l3 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din_3),
    .v_vsync(vs_3), .v_hsync(hs_3), .v_de(de_3), .v_pixel(px_3),
    .v_active_w(aw_3), .v_active_h(ah_3), .v_locked(lk_3), .v_err(er_3));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event observers on the VESA instance, sampled on the falling edge
  int   vs_hi = 0, err_pulses = 0, err_long = 0, err_misal = 0, lk_rise_bad = 0;
  logic err_prev = 1'b0, lk_prev = 1'b0;

  always @(negedge clk) begin
    if (vs_v === 1'b1) vs_hi++;
    if (er_v === 1'b1) begin
      if (err_prev === 1'b1) err_long++;
      else                   err_pulses++;
      if (lk_v !== 1'b0 || lk_prev !== 1'b1) err_misal++;
    end
    if (lk_v === 1'b1 && lk_prev === 1'b0 && vs_v !== 1'b1) lk_rise_bad++;
    err_prev = er_v;
    lk_prev  = lk_v;
  end

  // Serialise one pixel into the four lane words
  function automatic logic [27:0] enc4(input logic [7:0] r, g, b,
                                       input logic de, vs, hs, input logic jeida);
    logic [5:0] pr, pg, pb;
    logic [1:0] xr, xg, xb;
    if (jeida) begin
      pr = r[7:2]; pg = g[7:2]; pb = b[7:2];
      xr = r[1:0]; xg = g[1:0]; xb = b[1:0];
    end else begin
      pr = r[5:0]; pg = g[5:0]; pb = b[5:0];
      xr = r[7:6]; xg = g[7:6]; xb = b[7:6];
    end
    return {pg[0], pr, pb[1:0], pg[5:1], de, vs, hs, pb[5:2], 1'b0, xb, xg, xr};
  endfunction

  task automatic cyc(input logic de, input logic vs, input logic hs, input logic [7:0] px);
    logic [27:0] wv, wj;
    wv = enc4(px, px, px, de, vs, hs, 1'b0);
    wj = enc4(px, px, px, de, vs, hs, 1'b1);
    din_v = {wv, wv};
    din_j = {wj, wj};
    din_3 = {wj[27:7], wj[27:7]};
    @(posedge clk);
    #1;
  endtask

  // Frame: 2-cycle vsync, 1 blank, then h lines of w DE cycles + 2 blank.
  // Line number bad (if >=0) is one cycle short.
  task automatic send_frame(input int h, input int w, input int bad);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int l = 0; l < h; l++) begin
      for (int c = 0; c < ((l == bad) ? w - 1 : w); c++) cyc(1'b1, 1'b0, 1'b0, 8'(c + 1));
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0;
    din_v = '0; din_j = '0; din_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_vsync", 64'(vs_v), 64'd0);
    chk("rst_hsync", 64'(hs_v), 64'd0);
    chk("rst_de", 64'(de_v), 64'd0);
    chk("rst_pixel", 64'(px_v), 64'd0);
    chk("rst_locked", 64'(lk_v), 64'd0);
    chk("rst_err", 64'(er_v), 64'd0);
    chk("rst_active_w", 64'(aw_v), 64'd0);
    chk("rst_active_h", 64'(ah_v), 64'd0);

    // Hand-built lane words: ch0 R=A5 (DE=1,HS=0), ch1 G=3C B=C3 (HS=1)
    din_valid = 1'b1;
    din_v = {7'h25, 7'h00, 7'h40, 7'h02, 7'h00, 7'h7E, 7'h50, 7'h30};
    din_j = {7'h29, 7'h00, 7'h40, 7'h01, 7'h40, 7'h07, 7'h5C, 7'h30};
    din_3 = {7'h29, 7'h00, 7'h40, 7'h40, 7'h07, 7'h5C};
    @(posedge clk); #1;
    chk("lat1_de", 64'(de_v), 64'd0);
    chk("lat1_pixel", 64'(px_v), 64'd0);
    din_v = '0; din_j = '0; din_3 = '0;
    @(posedge clk); #1;
    chk("vec1_vesa_pixel", 64'(px_v), 64'h0000_A50000_003CC3);
    chk("vec1_jeida_pixel", 64'(px_j), 64'h0000_A50000_003CC3);
    chk("vec1_l3_pixel", 64'(px_3), 64'h0000_A40000_003CC0);
    chk("vec1_de", 64'(de_v), 64'd1);
    chk("vec1_hsync_ch0", 64'(hs_v), 64'd0);

    din_v = {7'h00, 7'h7E, 7'h50, 7'h30, 7'h25, 7'h00, 7'h40, 7'h02};
    din_j = {7'h40, 7'h07, 7'h5C, 7'h30, 7'h29, 7'h00, 7'h40, 7'h01};
    din_3 = {7'h40, 7'h07, 7'h5C, 7'h29, 7'h00, 7'h40};
    @(posedge clk); #1;
    din_v = '0; din_j = '0; din_3 = '0;
    @(posedge clk); #1;
    chk("vec2_vesa_pixel", 64'(px_v), 64'h0000_003CC3_A50000);
    chk("vec2_jeida_pixel", 64'(px_j), 64'h0000_003CC3_A50000);
    chk("vec2_l3_pixel", 64'(px_3), 64'h0000_003CC0_A40000);
    chk("vec2_hsync_ch0", 64'(hs_v), 64'd1);
    chk("vec2_l3_hsync", 64'(hs_3), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // 2 skipped + 2 training frames, lock on the 4th vsync rise
    send_frame(3, 4, -1);
    send_frame(3, 4, -1);
    send_frame(3, 4, -1);
    chk("train_vsync_hidden", 64'(vs_hi), 64'd0);
    chk("train_not_locked", 64'(lk_v), 64'd0);
    send_frame(3, 4, -1);
    chk("lock_locked", 64'(lk_v), 64'd1);
    chk("lock_vsync_cycles", 64'(vs_hi), 64'd2);
    chk("lock_active_w", 64'(aw_v), 64'd8);
    chk("lock_active_h", 64'(ah_v), 64'd3);
    chk("lock_jeida", 64'(lk_j), 64'd1);
    chk("lock_l3_active_w", 64'(aw_3), 64'd8);

    // Height change while locked
    send_frame(3, 4, -1);
    send_frame(4, 4, -1);
    chk("pre_break_vsync", 64'(vs_hi), 64'd6);
    chk("pre_break_locked", 64'(lk_v), 64'd1);
    send_frame(4, 4, -1);
    chk("break_err_pulses", 64'(err_pulses), 64'd1);
    chk("break_unlocked", 64'(lk_v), 64'd0);
    chk("break_vsync_hidden", 64'(vs_hi), 64'd6);
    chk("break_h_held", 64'(ah_v), 64'd3);
    send_frame(4, 4, -1);
    chk("relock_locked", 64'(lk_v), 64'd1);
    chk("relock_active_h", 64'(ah_v), 64'd4);
    chk("relock_vsync", 64'(vs_hi), 64'd8);
    send_frame(4, 4, -1);
    chk("locked_vsync", 64'(vs_hi), 64'd10);

    // din_valid drops mid-line while locked
    cyc(1'b1, 1'b0, 1'b0, 8'h5A);
    cyc(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("drop_pre_pixel", 64'(px_v), 64'h0000_5A5A5A_5A5A5A);
    din_valid = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("drop_1clk_de", 64'(de_v), 64'd1);
    chk("drop_1clk_locked", 64'(lk_v), 64'd1);
    cyc(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("drop_de", 64'(de_v), 64'd0);
    chk("drop_hsync", 64'(hs_v), 64'd0);
    chk("drop_vsync", 64'(vs_v), 64'd0);
    chk("drop_pixel", 64'(px_v), 64'd0);
    chk("drop_err", 64'(er_v), 64'd1);
    chk("drop_unlocked", 64'(lk_v), 64'd0);
    cyc(1'b1, 1'b1, 1'b1, 8'h5A);
    chk("drop_err_1cycle", 64'(er_v), 64'd0);
    chk("drop_err_pulses", 64'(err_pulses), 64'd2);
    chk("drop_h_held", 64'(ah_v), 64'd4);

    // Resume: skip again, one short line in the first training frame
    din_valid = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    send_frame(3, 4, -1);
    send_frame(3, 4, 1);
    send_frame(3, 4, -1);
    chk("resume_skip_vsync", 64'(vs_hi), 64'd10);
    send_frame(3, 4, -1);
    chk("badline_delays_lock", 64'(lk_v), 64'd0);
    chk("badline_vsync_hidden", 64'(vs_hi), 64'd10);
    send_frame(3, 4, -1);
    chk("resume_locked", 64'(lk_v), 64'd1);
    chk("resume_vsync", 64'(vs_hi), 64'd12);
    chk("resume_active_h", 64'(ah_v), 64'd3);
    chk("resume_active_w", 64'(aw_v), 64'd8);

    // Reset mid-line while locked
    cyc(1'b1, 1'b0, 1'b0, 8'h33);
    cyc(1'b1, 1'b0, 1'b0, 8'h33);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h33);
    chk("mrst_de", 64'(de_v), 64'd0);
    chk("mrst_pixel", 64'(px_v), 64'd0);
    chk("mrst_locked", 64'(lk_v), 64'd0);
    chk("mrst_err", 64'(er_v), 64'd0);
    chk("mrst_active_w", 64'(aw_v), 64'd0);
    chk("mrst_active_h", 64'(ah_v), 64'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("mrst_no_err_pulse", 64'(err_pulses), 64'd2);
    chk("mrst_still_unlocked", 64'(lk_v), 64'd0);

    chk("err_width", 64'(err_long), 64'd0);
    chk("err_alignment", 64'(err_misal), 64'd0);
    chk("lock_vsync_alignment", 64'(lk_rise_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
